// File: rtl/wb_gpio.sv
// wb_gpio: Wishbone B4 classic slave with 8 synchronised input pins and an
// 8-bit output register that also has set/clear/toggle write aliases.
// The slave drives the shared read-data net only while it acknowledges.
module wb_gpio #(
    parameter logic [31:0] BASE_ADDRESS = 32'h4000_0000
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        stb_i,
    input  logic        cyc_i,
    input  logic [31:0] adr_i,
    input  logic [3:0]  sel_i,
    input  logic [31:0] dat_i,
    output logic [31:0] dat_o,
    input  logic        we_i,
    output logic        ack_o,
    output logic        err_o,
    output logic        rty_o,
    input  logic [7:0]  pin_input,
    output logic [7:0]  pin_output
);

    // Word index (adr_i[7:2]) of each register in the 256-byte window.
    typedef enum logic [5:0] {
        REG_IN  = 6'h00,
        REG_OUT = 6'h01,
        REG_SET = 6'h02,
        REG_CLR = 6'h03,
        REG_TGL = 6'h04
    } reg_e;

    logic       hit;
    logic       accept;
    logic [5:0] word;

    logic       ack_q,   ack_d;
    logic [7:0] out_q,   out_d;
    logic [7:0] rdata_q, rdata_d;
    logic [7:0] sync1_q, sync1_d;
    logic [7:0] sync2_q, sync2_d;

    // Byte-lane bits 3:1, the upper write-data bytes and the byte offset
    // inside a word carry no meaning for an 8-bit, word-aligned register.
    logic unused_bits;
    assign unused_bits = ^{adr_i[1:0], sel_i[3:1], dat_i[31:8]};

    // Decode the request and compute the next state of every register.
    always_comb begin
        // NOTE: every signal gets a default first so no path leaves one
        // unassigned, which would otherwise infer a latch.
        hit     = cyc_i & stb_i & (adr_i[31:8] == BASE_ADDRESS[31:8]);
        accept  = hit & ~ack_q;
        word    = adr_i[7:2];
        ack_d   = accept;
        out_d   = out_q;
        rdata_d = rdata_q;
        sync1_d = pin_input;
        sync2_d = sync1_q;

        if (accept) begin
            if (we_i) begin
                // Write-only aliases and holes read back as zero anyway.
                rdata_d = 8'h00;
                if (sel_i[0]) begin
                    case (word)
                        REG_OUT: out_d = dat_i[7:0];
                        REG_SET: out_d = out_q | dat_i[7:0];
                        REG_CLR: out_d = out_q & ~dat_i[7:0];
                        REG_TGL: out_d = out_q ^ dat_i[7:0];
                        default: out_d = out_q;
                    endcase
                end
            end else begin
                case (word)
                    REG_IN:  rdata_d = sync2_q;
                    REG_OUT: rdata_d = out_q;
                    default: rdata_d = 8'h00;
                endcase
            end
        end
    end

    // Two-flop synchroniser for the asynchronous input pins.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            sync1_q <= 8'h00;
            sync2_q <= 8'h00;
        end else begin
            // NOTE: non-blocking assignments so both stages sample their
            // inputs from before the edge and form a true two-stage chain.
            sync1_q <= sync1_d;
            sync2_q <= sync2_d;
        end
    end

    // Bus-side state: acknowledge, output register and captured read data.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            ack_q   <= 1'b0;
            out_q   <= 8'h00;
            rdata_q <= 8'h00;
        end else begin
            ack_q   <= ack_d;
            out_q   <= out_d;
            rdata_q <= rdata_d;
        end
    end

    assign ack_o      = ack_q;
    assign pin_output = out_q;
    assign err_o      = 1'b0;
    assign rty_o      = 1'b0;
    // Release the shared read-data net whenever this slave is not acking.
    assign dat_o      = ack_q ? {24'h00_0000, rdata_q} : 32'hzzzz_zzzz;

endmodule

// File: tb/tb_wb_gpio.sv
// tb_wb_gpio: randomized scoreboard bench for wb_gpio. The driver pushes the
// expected response of every acknowledged access into a queue; a monitor
// pops and compares whenever the DUT raises ack_o.
module tb_wb_gpio;

    localparam logic [31:0] BASE = 32'h4000_0000;

    logic        clk_i     = 1'b0;
    logic        rst_i     = 1'b0;
    logic        stb_i     = 1'b0;
    logic        cyc_i     = 1'b0;
    logic        we_i      = 1'b0;
    logic [31:0] adr_i     = 32'h0;
    logic [31:0] dat_i     = 32'h0;
    logic [3:0]  sel_i     = 4'h0;
    logic [7:0]  pin_input = 8'h00;
    wire  [31:0] dat_o;
    logic        ack_o;
    logic        err_o;
    logic        rty_o;
    logic [7:0]  pin_output;

    wb_gpio #(.BASE_ADDRESS(BASE)) dut (
        .clk_i      (clk_i),
        .rst_i      (rst_i),
        .stb_i      (stb_i),
        .cyc_i      (cyc_i),
        .adr_i      (adr_i),
        .sel_i      (sel_i),
        .dat_i      (dat_i),
        .dat_o      (dat_o),
        .we_i       (we_i),
        .ack_o      (ack_o),
        .err_o      (err_o),
        .rty_o      (rty_o),
        .pin_input  (pin_input),
        .pin_output (pin_output)
    );

    always #5 clk_i = ~clk_i;

    int total = 0;
    int bad   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got %h, expected %h at %0t", name, act, req, $time);
        end
    endtask

    // Expected response of one acknowledged access.
    typedef struct {
        bit         is_write;
        logic [31:0] rdata;
        logic [7:0]  out_val;
    } exp_t;

    exp_t exp_q[$];
    exp_t mon_e;

    // Reference model: OUT register value and the pin value seen at each edge.
    // A read acked at edge k returns the pins as sampled at edge k-2.
    logic [7:0] m_out = 8'h00;
    logic [7:0] pin_hist[$] = '{8'h00, 8'h00};

    always @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            pin_hist = '{8'h00, 8'h00};
        end else begin
            pin_hist.push_back(pin_input);
            if (pin_hist.size() > 4) void'(pin_hist.pop_front());
        end
    end

    // Monitor: compare every acknowledge against the oldest expectation.
    always @(negedge clk_i) begin
        check("err_o_tied", {31'b0, err_o}, 32'h0);
        check("rty_o_tied", {31'b0, rty_o}, 32'h0);
        if (ack_o === 1'b1) begin
            if (exp_q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL spurious_ack: got ack_o=1, expected no acknowledge at %0t", $time);
            end else begin
                mon_e = exp_q.pop_front();
                if (!mon_e.is_write) check("read_data", dat_o, mon_e.rdata);
                check("pin_output_at_ack", {24'h0, pin_output}, {24'h0, mon_e.out_val});
            end
        end
    end

    task automatic bus_drive(input logic [31:0] adr, input logic we, input logic [31:0] dat,
                             input logic [3:0] sel, input logic cyc, input logic stb);
        @(posedge clk_i);
        #1;
        cyc_i = cyc;
        stb_i = stb;
        adr_i = adr;
        we_i  = we;
        dat_i = dat;
        sel_i = sel;
    endtask

    task automatic bus_release();
        cyc_i = 1'b0;
        stb_i = 1'b0;
        we_i  = 1'b0;
    endtask

    // Apply the register-map rules to the model and build the expectation.
    task automatic model_access(input logic [31:0] adr, input logic we, input logic [31:0] dat,
                                input logic [3:0] sel, output exp_t e);
        int w;
        w = int'(adr[7:0]) / 4;
        e.is_write = we;
        e.rdata    = 32'h0;
        if (we) begin
            if (sel[0]) begin
                if (w == 1) m_out = dat[7:0];
                else if (w == 2) m_out = m_out | dat[7:0];
                else if (w == 3) m_out = m_out & ~dat[7:0];
                else if (w == 4) m_out = m_out ^ dat[7:0];
            end
        end else begin
            if (w == 0) e.rdata = {24'h0, pin_hist[pin_hist.size() - 2]};
            else if (w == 1) e.rdata = {24'h0, m_out};
        end
        e.out_val = m_out;
    endtask

    // One in-window access: ack must be low in the request cycle and high in the next.
    task automatic do_access(input logic [31:0] adr, input logic we, input logic [31:0] dat,
                             input logic [3:0] sel);
        exp_t e;
        bus_drive(adr, we, dat, sel, 1'b1, 1'b1);
        model_access(adr, we, dat, sel, e);
        exp_q.push_back(e);
        @(negedge clk_i);
        check("ack_not_early", {31'b0, ack_o}, 32'h0);
        @(negedge clk_i);
        check("ack_one_cycle", {31'b0, ack_o}, 32'h1);
        @(posedge clk_i);
        #1;
        bus_release();
    endtask

    // A request that must not be acknowledged nor change OUT.
    task automatic do_miss(input logic [31:0] adr, input logic cyc, input logic stb);
        bus_drive(adr, 1'b1, $urandom, 4'hF, cyc, stb);
        repeat (3) begin
            @(negedge clk_i);
            check("miss_no_ack", {31'b0, ack_o}, 32'h0);
        end
        check("miss_out_kept", {24'h0, pin_output}, {24'h0, m_out});
        @(posedge clk_i);
        #1;
        bus_release();
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [31:0] adr;
        logic [7:0]  offs[6] = '{8'h00, 8'h04, 8'h08, 8'h0C, 8'h10, 8'h00};
        exp_t        e;

        // Reset state.
        repeat (2) @(posedge clk_i);
        @(negedge clk_i);
        check("reset_pin_output", {24'h0, pin_output}, 32'h0);
        check("reset_ack", {31'b0, ack_o}, 32'h0);
        @(posedge clk_i);
        #1;
        rst_i = 1'b1;

        // Directed register-map sequence.
        do_access(BASE + 32'h00, 1'b0, 32'h0, 4'hF);
        do_access(BASE + 32'h04, 1'b1, 32'h0000_00A5, 4'hF);
        check("out_write_a5", {24'h0, pin_output}, 32'hA5);
        do_access(BASE + 32'h04, 1'b0, 32'h0, 4'hF);
        do_access(BASE + 32'h08, 1'b1, 32'h0000_000A, 4'hF);
        check("out_set_af", {24'h0, pin_output}, 32'hAF);
        do_access(BASE + 32'h0C, 1'b1, 32'h0000_0081, 4'hF);
        check("out_clr_2e", {24'h0, pin_output}, 32'h2E);
        do_access(BASE + 32'h10, 1'b1, 32'h0000_00FF, 4'hF);
        check("out_tgl_d1", {24'h0, pin_output}, 32'hD1);
        do_access(BASE + 32'h08, 1'b0, 32'h0, 4'hF);

        // Input synchroniser latency: read right after the change, then later.
        @(posedge clk_i);
        #1;
        pin_input = 8'h01;
        do_access(BASE + 32'h00, 1'b0, 32'h0, 4'hF);
        do_access(BASE + 32'h00, 1'b0, 32'h0, 4'hF);

        // Address and qualifier checks.
        do_miss(32'h3000_0000, 1'b1, 1'b1);
        do_miss(BASE + 32'h04, 1'b0, 1'b1);
        do_miss(BASE + 32'h04, 1'b1, 1'b0);
        do_access(BASE + 32'h20, 1'b0, 32'h0, 4'hF);
        do_access(BASE + 32'h20, 1'b1, 32'h0000_0033, 4'hF);
        do_access(BASE + 32'h04, 1'b1, 32'h0000_0055, 4'hE);
        check("sel_e_no_write", {24'h0, pin_output}, 32'hD1);

        // Strobe held for four cycles: two acks, pattern 0,1,0,1.
        bus_drive(BASE + 32'h04, 1'b0, 32'h0, 4'hF, 1'b1, 1'b1);
        model_access(BASE + 32'h04, 1'b0, 32'h0, 4'hF, e);
        exp_q.push_back(e);
        exp_q.push_back(e);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk_i);
            check("held_stb_ack", {31'b0, ack_o}, (i % 2 == 1) ? 32'h1 : 32'h0);
        end
        @(posedge clk_i);
        #1;
        bus_release();

        // Reset in the middle of a write: dropped without acknowledge.
        bus_drive(BASE + 32'h04, 1'b1, 32'h0000_005A, 4'hF, 1'b1, 1'b1);
        @(negedge clk_i);
        rst_i = 1'b0;
        m_out = 8'h00;
        #1;
        check("rst_mid_ack", {31'b0, ack_o}, 32'h0);
        check("rst_mid_out", {24'h0, pin_output}, 32'h0);
        @(posedge clk_i);
        #1;
        check("rst_hold_ack", {31'b0, ack_o}, 32'h0);
        check("rst_hold_out", {24'h0, pin_output}, 32'h0);
        bus_release();
        @(posedge clk_i);
        #1;
        rst_i = 1'b1;
        do_access(BASE + 32'h04, 1'b0, 32'h0, 4'hF);

        // Randomized traffic against the model.
        for (int n = 0; n < 300; n++) begin
            if ($urandom_range(0, 3) == 0) begin
                @(posedge clk_i);
                #1;
                pin_input = 8'($urandom);
            end
            if ($urandom_range(0, 9) == 0) begin
                adr = $urandom;
                if (adr[31:8] == BASE[31:8]) adr[31] = ~adr[31];
                do_miss(adr, 1'b1, 1'b1);
            end else begin
                adr = BASE;
                if ($urandom_range(0, 7) == 0) adr[7:2] = 6'($urandom_range(5, 63));
                else adr[7:0] = offs[$urandom_range(0, 5)];
                do_access(adr, 1'($urandom), $urandom, 4'($urandom_range(0, 15)));
            end
        end

        repeat (3) @(negedge clk_i);
        check("scoreboard_drained", exp_q.size(), 32'h0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
